// File: rtl/tartaruga_pkg.sv
// Shared tartaruga types and constants: bus width, program-image depth and the
// instruction-fetch response record.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  localparam int unsigned IMEM_POS         = 4096;
  localparam int unsigned IMEM_LINE_W      = 128;
  localparam int unsigned IMEM_DEFAULT_LAT = 5;

  typedef struct packed {
    bus32_t                 addr;
    logic                   err;
    logic [IMEM_LINE_W-1:0] line;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// First-word-fall-through response FIFO; head is valid in the same cycle the
// entry lands. Writers must never push while full.
module imem_rsp_fifo
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = imem_rsp_t
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic valid,
  output T     head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && valid;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers and count define
  // what is valid, so clearing the array would just add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_pipe_model.sv
// Pipelined instruction-memory model: up to MAX_OUT fetches in flight, fixed
// LAT-cycle latency, in-order responses through a backpressured FWFT FIFO.
module imem_pipe_model #(
  parameter int unsigned LAT            = tartaruga_pkg::IMEM_DEFAULT_LAT,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IMEM_POS       = tartaruga_pkg::IMEM_POS,
  parameter int unsigned MAX_OUT        = LAT + 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [31:0]                   pc_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_mem_addr_o,
  output logic                          rsp_err_o,
  output logic [32*WORDS_PER_LINE-1:0]  instr_line_o
);

  import tartaruga_pkg::*;

  localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;
  localparam int unsigned AW     = $clog2(IMEM_POS);
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);

  typedef struct packed {
    bus32_t            addr;
    logic              err;
    logic [LINE_W-1:0] line;
  } rsp_t;

  // The image is a pure function of the word index, so it is evaluated at read
  // time instead of being copied into an array.
  function automatic int unsigned read_mem(input int unsigned idx);
    return idx + 32'h1000;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             rsp_hs;
  logic             push;
  rsp_t             push_data;
  rsp_t             stage_in;
  rsp_t             head;
  logic [AW-1:0]    base;
  logic [AW-1:0]    word_idx;

  assign req_ready_o = (cnt < CNT_W'(MAX_OUT)) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  // Credits cover everything accepted but not yet handed to the consumer, so
  // the FIFO (same depth) can never overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept && !rsp_hs) begin
      cnt <= cnt + 1'b1;
    end else if (!accept && rsp_hs) begin
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: every variable written here gets a default first so no path through
  // the block leaves a value held, which would infer a latch.
  always_comb begin
    stage_in      = '0;
    word_idx      = '0;
    stage_in.addr = pc_i;
    stage_in.err  = (pc_i[1:0] != 2'b00);
    base          = pc_i[AW+1:2];
    if (!stage_in.err) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        word_idx                 = base + AW'(k);
        stage_in.line[32*k +: 32] = read_mem(32'(word_idx));
      end
    end
  end

  // The FIFO write is the last of the LAT register stages.
  if (LAT == 1) begin : g_direct
    assign push      = accept;
    assign push_data = stage_in;
  end else begin : g_pipe
    logic [LAT-2:0] vld_q;
    rsp_t           data_q [LAT-1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        vld_q <= '0;
      end else if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < LAT - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      data_q[0] <= stage_in;
      for (int i = 1; i < LAT - 1; i++) data_q[i] <= data_q[i-1];
    end

    assign push      = vld_q[LAT-2];
    assign push_data = data_q[LAT-2];
  end

  imem_rsp_fifo #(
    .DEPTH (MAX_OUT),
    .T     (rsp_t)
  ) u_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear     (flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_hs),
    .valid     (rsp_valid_o),
    .head      (head)
  );

  assign rsp_mem_addr_o = rsp_valid_o ? head.addr : '0;
  assign rsp_err_o      = rsp_valid_o ? head.err  : 1'b0;
  assign instr_line_o   = rsp_valid_o ? head.line : '0;

endmodule

// File: tb/tb_imem_pipe_model.sv
// Self-checking bench for imem_pipe_model: a queue of outstanding fetches with
// due cycles predicts every output each cycle; scenario tasks add directed checks.
module tb_imem_pipe_model;

  localparam int unsigned LAT     = 5;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned POS     = 4096;
  localparam int unsigned MAX_OUT = LAT + 1;

  logic         clk;
  logic         rstn;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  pc;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_addr;
  logic         rsp_err;
  logic [127:0] line;

  imem_pipe_model #(
    .LAT            (LAT),
    .WORDS_PER_LINE (WORDS),
    .IMEM_POS       (POS),
    .MAX_OUT        (MAX_OUT)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .pc_i           (pc),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_mem_addr_o (rsp_addr),
    .rsp_err_o      (rsp_err),
    .instr_line_o   (line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc;
  int          compared;
  int          mismatched;

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    l = '0;
    if (a[1:0] == 2'b00)
      for (int k = 0; k < WORDS; k++)
        l[32*k +: 32] = 32'h1000 + (((a >> 2) + k) % POS);
    return l;
  endfunction

  // One clock cycle: drive, predict and compare all outputs, then advance the model.
  task automatic step(input logic v, input logic [31:0] p, input logic rdy, input logic fl,
                      output logic gv, output logic [31:0] ga, output logic ge,
                      output logic [127:0] gl, output logic gr);
    logic         e_ready, e_valid, e_err;
    logic [31:0]  e_addr;
    logic [127:0] e_line;
    @(negedge clk);
    req_valid = v; pc = p; rsp_ready = rdy; flush = fl;
    #1;
    e_ready = (q.size() < MAX_OUT) && !fl;
    e_valid = (q.size() > 0) && (cyc >= q[0].due);
    e_addr  = e_valid ? q[0].addr : 32'h0;
    e_err   = e_valid ? (q[0].addr[1:0] != 2'b00) : 1'b0;
    e_line  = e_valid ? model_line(q[0].addr) : 128'h0;
    compared++;
    if (req_ready !== e_ready) begin
      mismatched++; $display("FAIL req_ready cyc=%0d got %b want %b", cyc, req_ready, e_ready);
    end
    compared++;
    if (rsp_valid !== e_valid) begin
      mismatched++; $display("FAIL rsp_valid cyc=%0d got %b want %b", cyc, rsp_valid, e_valid);
    end
    compared++;
    if (rsp_addr !== e_addr || rsp_err !== e_err) begin
      mismatched++;
      $display("FAIL rsp_addr/err cyc=%0d got %h/%b want %h/%b", cyc, rsp_addr, rsp_err, e_addr, e_err);
    end
    compared++;
    if (line !== e_line) begin
      mismatched++; $display("FAIL instr_line cyc=%0d got %h want %h", cyc, line, e_line);
    end
    gv = rsp_valid; ga = rsp_addr; ge = rsp_err; gl = line; gr = req_ready;
    @(posedge clk);
    if (e_valid && rdy) void'(q.pop_front());
    if (v && e_ready) q.push_back('{p, cyc + LAT});
    if (fl) q.delete();
    cyc++;
  endtask

  task automatic check_zero_outputs(input string tag);
    compared++;
    if (rsp_valid !== 1'b0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0 || line !== 128'h0) begin
      mismatched++;
      $display("FAIL %s outputs got v=%b a=%h e=%b l=%h want all zero", tag, rsp_valid, rsp_addr, rsp_err, line);
    end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++; $display("FAIL %s req_ready got %b want 1", tag, req_ready);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; pc = '0;
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
  endtask

  task automatic test_single();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    int seen; logic [127:0] got_line;
    seen = -1; got_line = '0;
    step(1'b1, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (gv && seen < 0) begin seen = j; got_line = gl; end
    end
    compared++;
    if (seen != LAT) begin
      mismatched++; $display("FAIL single_latency got %0d want %0d", seen, LAT);
    end
    compared++;
    if (got_line !== 128'h00001003_00001002_00001001_00001000) begin
      mismatched++; $display("FAIL single_line got %h", got_line);
    end
  endtask

  task automatic test_back_to_back();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    int n; int first, last;
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 8, 32'(i * 16), 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (i < 8) begin
        compared++;
        if (gr !== 1'b1) begin
          mismatched++; $display("FAIL stream_ready i=%0d got %b want 1", i, gr);
        end
      end
      if (gv) begin
        compared++;
        if (ga !== 32'(n * 16) || gl[31:0] !== 32'(32'h1000 + 4 * n)) begin
          mismatched++;
          $display("FAIL stream_order n=%0d got %h/%h want %h/%h", n, ga, gl[31:0], n * 16, 32'h1000 + 4 * n);
        end
        if (first < 0) first = i;
        last = i; n++;
      end
    end
    compared++;
    if (n != 8 || last - first != 7) begin
      mismatched++; $display("FAIL stream_count got %0d over %0d cycles want 8 over 8", n, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    int acc, n; logic prev_hs;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i * 16), 1'b0, 1'b0, gv, ga, ge, gl, gr);
      if (gr) acc++;
      if (gv) begin
        compared++;
        if (ga !== 32'h0) begin
          mismatched++; $display("FAIL bp_stable i=%0d got %h want 0", i, ga);
        end
      end
    end
    compared++;
    if (acc != MAX_OUT || gr !== 1'b0) begin
      mismatched++; $display("FAIL bp_accepts got %0d (ready %b) want %0d (ready 0)", acc, gr, MAX_OUT);
    end
    n = 0; prev_hs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (prev_hs && n == 1) begin
        compared++;
        if (gr !== 1'b1) begin
          mismatched++; $display("FAIL bp_ready_return got %b want 1", gr);
        end
      end
      prev_hs = gv;
      if (gv) begin
        compared++;
        if (ga !== 32'(n * 16)) begin
          mismatched++; $display("FAIL bp_order n=%0d got %h want %h", n, ga, n * 16);
        end
        n++;
      end
    end
    compared++;
    if (n != MAX_OUT) begin
      mismatched++; $display("FAIL bp_drain got %0d want %0d", n, MAX_OUT);
    end
  endtask

  task automatic test_wrap_err();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    logic [31:0] pcs [3];
    int n;
    pcs[0] = 32'h3FF8; pcs[1] = 32'h2; pcs[2] = 32'h4;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 3, (i < 3) ? pcs[i] : 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (gv && n < 3) begin
        compared++;
        if (ga !== pcs[n]) begin
          mismatched++; $display("FAIL wrap_order n=%0d got %h want %h", n, ga, pcs[n]);
        end
        if (n == 0) begin
          compared++;
          if (gl !== 128'h00001001_00001000_00001FFF_00001FFE || ge !== 1'b0) begin
            mismatched++; $display("FAIL wrap_line got %h err %b", gl, ge);
          end
        end
        if (n == 1) begin
          compared++;
          if (ge !== 1'b1 || gl !== 128'h0) begin
            mismatched++; $display("FAIL misalign got err %b line %h want err 1 line 0", ge, gl);
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_flush();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    int stale, seen;
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h100 + i * 4), 1'b0, 1'b0, gv, ga, ge, gl, gr);
    step(1'b0, 32'h0, 1'b0, 1'b0, gv, ga, ge, gl, gr);
    step(1'b0, 32'h0, 1'b0, 1'b1, gv, ga, ge, gl, gr);
    compared++;
    if (gv !== 1'b1) begin
      mismatched++; $display("FAIL flush_setup queued got %b want 1", gv);
    end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (gv) stale++;
      if (i == 0) begin
        compared++;
        if (gr !== 1'b1) begin
          mismatched++; $display("FAIL flush_ready got %b want 1", gr);
        end
      end
    end
    compared++;
    if (stale != 0) begin
      mismatched++; $display("FAIL flush_stale got %0d want 0", stale);
    end
    seen = -1;
    step(1'b1, 32'h20, 1'b1, 1'b0, gv, ga, ge, gl, gr);
    for (int j = 1; j <= 7; j++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (gv && seen < 0) begin
        seen = j;
        compared++;
        if (gl !== 128'h0000100B_0000100A_00001009_00001008) begin
          mismatched++; $display("FAIL flush_refetch line got %h", gl);
        end
      end
    end
    compared++;
    if (seen != LAT) begin
      mismatched++; $display("FAIL flush_refetch_latency got %0d want %0d", seen, LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    int seen;
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h200 + i * 16), 1'b1, 1'b0, gv, ga, ge, gl, gr);
    @(negedge clk);
    req_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero_outputs("reset_mid");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = -1;
    step(1'b1, 32'h40, 1'b1, 1'b0, gv, ga, ge, gl, gr);
    for (int j = 1; j <= 7; j++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
      if (gv && seen < 0) begin
        seen = j;
        compared++;
        if (ga !== 32'h40 || gl !== model_line(32'h40)) begin
          mismatched++; $display("FAIL reset_mid_first got %h/%h want 00000040", ga, gl);
        end
      end
    end
    compared++;
    if (seen != LAT) begin
      mismatched++; $display("FAIL reset_mid_latency got %0d want %0d", seen, LAT);
    end
  endtask

  task automatic test_random();
    logic gv, ge, gr; logic [31:0] ga; logic [127:0] gl;
    logic [31:0] p;
    for (int i = 0; i < 400; i++) begin
      p = $urandom;
      if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, gv, ga, ge, gl, gr);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0, gv, ga, ge, gl, gr);
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap_err();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
